// File: rtl/ped_crossing_control_if.sv
// Vehicle light inputs, push buttons and crosswalk lamp outputs
// shared between the pedestrian crossing controller and its driver.
interface ped_crossing_control_if;
  logic       Red_NS, Yellow_NS, Green_NS;
  logic       Red_EW, Yellow_EW, Green_EW;
  logic       btn_NS, btn_EW;
  logic       walk_NS, walk_EW;
  logic       dont_walk_NS, dont_walk_EW;
  logic [4:0] countdown_NS, countdown_EW;
  logic       req_pending_NS, req_pending_EW;
  logic       fault_NS, fault_EW;

  modport master (
    output Red_NS, Yellow_NS, Green_NS,
    output Red_EW, Yellow_EW, Green_EW,
    output btn_NS, btn_EW,
    input  walk_NS, walk_EW,
    input  dont_walk_NS, dont_walk_EW,
    input  countdown_NS, countdown_EW,
    input  req_pending_NS, req_pending_EW,
    input  fault_NS, fault_EW
  );

  modport slave (
    input  Red_NS, Yellow_NS, Green_NS,
    input  Red_EW, Yellow_EW, Green_EW,
    input  btn_NS, btn_EW,
    output walk_NS, walk_EW,
    output dont_walk_NS, dont_walk_EW,
    output countdown_NS, countdown_EW,
    output req_pending_NS, req_pending_EW,
    output fault_NS, fault_EW
  );
endinterface

// File: rtl/ped_crossing_control.sv
// Two-crosswalk pedestrian controller: WALK / flashing DON'T WALK
// served on a clean red rise, aborted the moment that red is lost.
module ped_crossing_control #(
  parameter logic [4:0] WALK_TIME  = 5'd4,
  parameter logic [4:0] FLASH_TIME = 5'd4,
  parameter logic [4:0] FLASH_HALF = 5'd1
) (
  input logic                   clk,
  input logic                   reset,
  ped_crossing_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_DONT_WALK = 2'd0,
    S_WALK      = 2'd1,
    S_FLASH     = 2'd2
  } state_t;

  // Index 0 is the NS crosswalk (over the EW road), index 1 the EW one.
  logic       w_permit [2];
  logic       w_btn [2];
  logic       w_rise [2];

  state_t     r_state [2];
  state_t     w_state_nxt [2];
  logic [4:0] r_timer [2];
  logic [4:0] w_timer_nxt [2];
  logic [4:0] r_phase [2];
  logic [4:0] w_phase_nxt [2];
  logic       r_flash_dw [2];
  logic       w_flash_dw_nxt [2];
  logic       r_permit_q [2];
  logic       r_req [2];
  logic       w_req_nxt [2];
  logic       r_fault [2];
  logic       w_fault_nxt [2];

  logic       w_walk [2];
  logic       w_dont_walk [2];
  logic [4:0] w_countdown [2];

  assign w_permit[0] = bus.Red_EW & ~bus.Yellow_EW & ~bus.Green_EW;
  assign w_permit[1] = bus.Red_NS & ~bus.Yellow_NS & ~bus.Green_NS;
  assign w_btn[0]    = bus.btn_NS;
  assign w_btn[1]    = bus.btn_EW;
  assign w_rise[0]   = w_permit[0] & ~r_permit_q[0];
  assign w_rise[1]   = w_permit[1] & ~r_permit_q[1];

  // permit_q resets high so a red already showing at release is not a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]    <= S_DONT_WALK;
        r_timer[i]    <= 5'd0;
        r_phase[i]    <= 5'd0;
        r_flash_dw[i] <= 1'b1;
        r_permit_q[i] <= 1'b1;
        r_req[i]      <= 1'b0;
        r_fault[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_timer[i]    <= w_timer_nxt[i];
        r_phase[i]    <= w_phase_nxt[i];
        r_flash_dw[i] <= w_flash_dw_nxt[i];
        r_permit_q[i] <= w_permit[i];
        r_req[i]      <= w_req_nxt[i];
        r_fault[i]    <= w_fault_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i]    = r_state[i];
      w_timer_nxt[i]    = r_timer[i];
      w_phase_nxt[i]    = r_phase[i];
      w_flash_dw_nxt[i] = r_flash_dw[i];
      w_req_nxt[i]      = r_req[i];
      w_fault_nxt[i]    = 1'b0;
      unique case (r_state[i])
        S_DONT_WALK: begin
          if (w_rise[i] && (r_req[i] || w_btn[i])) begin
            w_state_nxt[i] = S_WALK;
            w_timer_nxt[i] = WALK_TIME;
            w_req_nxt[i]   = 1'b0;
          end else if (w_btn[i]) begin
            w_req_nxt[i] = 1'b1;
          end
        end
        S_WALK: begin
          if (!w_permit[i]) begin
            w_state_nxt[i] = S_DONT_WALK;
            w_fault_nxt[i] = 1'b1;
            w_req_nxt[i]   = 1'b1;
          end else if (r_timer[i] <= 5'd1) begin
            w_state_nxt[i]    = S_FLASH;
            w_timer_nxt[i]    = FLASH_TIME;
            w_phase_nxt[i]    = FLASH_HALF;
            w_flash_dw_nxt[i] = 1'b1;
          end else begin
            w_timer_nxt[i] = r_timer[i] - 5'd1;
          end
        end
        S_FLASH: begin
          if (!w_permit[i]) begin
            w_state_nxt[i] = S_DONT_WALK;
            w_fault_nxt[i] = 1'b1;
            w_req_nxt[i]   = 1'b1;
          end else begin
            if (w_btn[i])
              w_req_nxt[i] = 1'b1;
            if (r_timer[i] <= 5'd1)
              w_state_nxt[i] = S_DONT_WALK;
            else
              w_timer_nxt[i] = r_timer[i] - 5'd1;
            if (r_phase[i] <= 5'd1) begin
              w_flash_dw_nxt[i] = ~r_flash_dw[i];
              w_phase_nxt[i]    = FLASH_HALF;
            end else begin
              w_phase_nxt[i] = r_phase[i] - 5'd1;
            end
          end
        end
        default: w_state_nxt[i] = S_DONT_WALK;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_walk[i]      = 1'b0;
      w_dont_walk[i] = 1'b1;
      w_countdown[i] = 5'd0;
      unique case (r_state[i])
        S_WALK: begin
          w_walk[i]      = 1'b1;
          w_dont_walk[i] = 1'b0;
        end
        S_FLASH: begin
          w_dont_walk[i] = r_flash_dw[i];
          w_countdown[i] = r_timer[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.walk_NS        = w_walk[0];
  assign bus.walk_EW        = w_walk[1];
  assign bus.dont_walk_NS   = w_dont_walk[0];
  assign bus.dont_walk_EW   = w_dont_walk[1];
  assign bus.countdown_NS   = w_countdown[0];
  assign bus.countdown_EW   = w_countdown[1];
  assign bus.req_pending_NS = r_req[0];
  assign bus.req_pending_EW = r_req[1];
  assign bus.fault_NS       = r_fault[0];
  assign bus.fault_EW       = r_fault[1];

endmodule

// File: doc/ped_crossing_control.md
# ped_crossing_control

Pedestrian crossing controller sitting directly downstream of the four-phase intersection light controller. It watches the NS and EW vehicle light outputs, latches pedestrian push-button requests, and drives WALK / flashing DON'T WALK signals plus a flash countdown for two crosswalks. A crosswalk serves only a request present at the start of a clean red phase on the road it crosses. It aborts immediately if that red is lost.

## Interface
- WALK_TIME, 5'd4, cycles of steady WALK (legal range 1..31)
- FLASH_TIME, 5'd4, cycles of flashing DON'T WALK after WALK (legal range 1..31)
- FLASH_HALF, 5'd1, cycles per flash half-period (legal range 1..31)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- Red_NS, Yellow_NS, Green_NS  input  1 each  NS vehicle lights from the intersection controller
- Red_EW, Yellow_EW, Green_EW  input  1 each  EW vehicle lights from the intersection controller
- btn_NS  input  1  push button, crosswalk over the EW road
- btn_EW  input  1  push button, crosswalk over the NS road
- walk_NS, walk_EW  output  1 each  steady WALK lamp
- dont_walk_NS, dont_walk_EW  output  1 each  DON'T WALK lamp, flashing in FLASH
- countdown_NS, countdown_EW  output  5 each  remaining FLASH cycles, 0 outside FLASH
- req_pending_NS, req_pending_EW  output  1 each  latched request not yet served
- fault_NS, fault_EW  output  1 each  one-cycle pulse on safety abort

## Operation
- There are two identical, independent channels. Channel NS uses permit_NS = Red_EW & ~Yellow_EW & ~Green_EW. Channel EW uses permit_EW = Red_NS & ~Yellow_NS & ~Green_NS.
- Per channel:
  - permit_q is a registered copy of permit.
  - rise = permit & ~permit_q.
- The req latch is set at an edge where btn=1 in state DONT_WALK or FLASH. btn is ignored in WALK. req is cleared on entry to WALK.
- The state machine has three states: DONT_WALK, WALK, FLASH.
  - DONT_WALK -> WALK when rise & (req | btn). Load the timer with WALK_TIME.
  - WALK -> FLASH when the timer expires after exactly WALK_TIME cycles. Load the timer with FLASH_TIME and the phase counter with FLASH_HALF.
  - FLASH -> DONT_WALK after exactly FLASH_TIME cycles.
  - WALK or FLASH -> DONT_WALK at any edge where permit=0. This is an abort:
    - fault pulses high for 1 cycle.
    - req is set to 1 so the pedestrian is served at the next rise.
    - Abort has priority over timer expiry and over btn.
- All outputs are registered and derived from state:
  - DONT_WALK: walk=0, dont_walk=1, countdown=0.
  - WALK: walk=1, dont_walk=0, countdown=0.
  - FLASH: walk=0.
    - dont_walk=1 for the first FLASH_HALF cycles, then toggles every FLASH_HALF cycles.
    - countdown shows FLASH_TIME on the first FLASH cycle and decrements to 1 on the last.
- Counters are 5-bit unsigned with no wrap. Loaded values are always ≥1.
- A button held high across many cycles counts as one request.

## Timing
- Reset values while reset is high:
  - state=DONT_WALK, walk=0, dont_walk=1, countdown=0, req=0, fault=0.
  - permit_q=1, so a red phase already in progress at reset release does not start a walk.
- A request pending or arriving on the rise edge gives walk=1 in the cycle after the edge where permit first reads 1.
- A request arriving while permit is already high waits for the next rise; req_pending stays 1 meanwhile.
- Total served window is WALK_TIME+FLASH_TIME cycles. If the red phase is shorter, the abort path is taken.
- Abort latency: walk and dont_walk reach the DONT_WALK values one edge after permit samples 0.
- Reset mid-WALK or mid-FLASH returns all outputs to reset values asynchronously. Any pending request is dropped.
- Channels never interact. Both may be active only if the inputs are illegal (both reds with no green). No cross-check is performed.

## Test plan
- Reset, hold btn_NS=0, run two full light cycles -> walk_NS=0, dont_walk_NS=1, countdown_NS=0 throughout, and the same on EW.
- Pulse btn_NS for 1 cycle during EW green, then let Red_EW rise with defaults:
  - req_pending_NS=1 until entry to WALK.
  - walk_NS=1 for exactly 4 cycles.
  - Then 4 FLASH cycles with dont_walk_NS=1,0,1,0 and countdown_NS=4,3,2,1.
  - Then steady DON'T WALK.
- Press btn_EW 2 cycles after Red_NS rises -> no walk this phase, req_pending_EW stays 1, and the walk starts on the next Red_NS rise.
- WALK_TIME=8 with a red phase of 5 cycles -> fault_NS pulses 1 cycle one edge after Red_EW drops, walk_NS=0, and req_pending_NS=1.
- Assert reset during FLASH, with btn held during reset -> outputs take reset values immediately. No walk after release until a fresh press and the next rise.
- FLASH_HALF=2, FLASH_TIME=4 -> dont_walk pattern in FLASH is 1,1,0,0.
